// File: rtl/spi_erisim_hakemi_pkg.sv
// Shared widths, TileLink field layouts and arbiter state encoding for the
// SPI controller access arbiter.
package spi_erisim_hakemi_pkg;

  localparam int unsigned ADRES_BIT = 32;
  localparam int unsigned VERI_BIT  = 32;
  localparam int unsigned TL_A_BITS = 8;
  localparam int unsigned TL_D_BITS = 8;
  localparam int unsigned TL_OP_BIT = 3;

  localparam logic [TL_OP_BIT-1:0] TL_OP_ACK      = 3'd0;
  localparam logic [TL_OP_BIT-1:0] TL_OP_ACK_DATA = 3'd1;

  localparam int unsigned KILIT_ZAMAN_ASIMI_VARSAYILAN = 1024;

  typedef enum logic [1:0] {
    BOSTA       = 2'd0,
    ISTEK       = 2'd1,
    YANIT_BEKLE = 2'd2,
    KILITLI     = 2'd3
  } hakem_durum_e;

  // A-channel request payload as forwarded to the controller
  typedef struct packed {
    logic [ADRES_BIT-1:0] adres;
    logic [VERI_BIT-1:0]  veri;
    logic [TL_A_BITS-1:0] tilefields;
  } a_istek_t;

  // D-channel fields; opcode sits in the low bits
  typedef struct packed {
    logic [TL_D_BITS-TL_OP_BIT-1:0] diger;
    logic [TL_OP_BIT-1:0]           op;
  } tl_d_t;

endpackage

// File: rtl/spi_erisim_hakemi_rr_hakem2.sv
// Two-input round-robin grant: the pointed-to requester wins when valid.
module spi_erisim_hakemi_rr_hakem2 (
  input  logic [1:0] gecerli,
  input  logic       rr,
  output logic [1:0] grant
);

  always_comb begin
    grant = '0;
    if (gecerli[rr])       grant[rr]  = 1'b1;
    else if (gecerli[~rr]) grant[~rr] = 1'b1;
  end

endmodule

// File: rtl/spi_erisim_hakemi.sv
// Round-robin, lockable arbiter sharing the spi_denetleyici request/response
// port between the core data port (0) and the boot loader (1).
module spi_erisim_hakemi
  import spi_erisim_hakemi_pkg::*;
#(
  parameter int unsigned KILIT_ZAMAN_ASIMI = KILIT_ZAMAN_ASIMI_VARSAYILAN
) (
  input  logic                   clk_i,
  input  logic                   rstn_i,
  input  logic [2*ADRES_BIT-1:0] ist_adres_i,
  input  logic [2*VERI_BIT-1:0]  ist_veri_i,
  input  logic [2*TL_A_BITS-1:0] ist_tilefields_i,
  input  logic [1:0]             ist_gecerli_i,
  output logic [1:0]             ist_hazir_o,
  input  logic [1:0]             ist_kilit_i,
  output logic [VERI_BIT-1:0]    yanit_veri_o,
  output logic [TL_D_BITS-1:0]   yanit_tilefields_o,
  output logic [1:0]             yanit_gecerli_o,
  input  logic [1:0]             yanit_hazir_i,
  output logic [ADRES_BIT-1:0]   alt_adres_o,
  output logic [VERI_BIT-1:0]    alt_veri_o,
  output logic [TL_A_BITS-1:0]   alt_tilefields_o,
  output logic                   alt_gecerli_o,
  input  logic                   alt_hazir_i,
  input  logic [VERI_BIT-1:0]    alt_yanit_veri_i,
  input  logic [TL_D_BITS-1:0]   alt_yanit_tilefields_i,
  input  logic                   alt_yanit_gecerli_i,
  output logic                   alt_yanit_hazir_o,
  output logic [1:0]             kilit_sahibi_o
);

  hakem_durum_e durum_r, durum_d;
  logic         sahip_r, sahip_d;
  logic         rr_r, rr_d;
  logic [31:0]  sayac_r, sayac_d;
  a_istek_t     alt_istek_r, alt_istek_d;
  logic         alt_gecerli_r, alt_gecerli_d;
  logic [1:0]   kilit_r, kilit_d;
  logic [1:0]   grant;
  logic         yanit_tamam;
  tl_d_t        d_alan;
  a_istek_t     istek [2];

  for (genvar k = 0; k < 2; k++) begin : g_istek
    assign istek[k] = {ist_adres_i[k*ADRES_BIT +: ADRES_BIT],
                       ist_veri_i[k*VERI_BIT +: VERI_BIT],
                       ist_tilefields_i[k*TL_A_BITS +: TL_A_BITS]};
  end

  spi_erisim_hakemi_rr_hakem2 u_rr (
    .gecerli (ist_gecerli_i),
    .rr      (rr_r),
    .grant   (grant)
  );

  assign d_alan      = tl_d_t'(alt_yanit_tilefields_i);
  // ACK pulses are dropped by the controller after one cycle, so they complete without ready
  assign yanit_tamam = alt_yanit_gecerli_i &&
                       (yanit_hazir_i[sahip_r] || (d_alan.op == TL_OP_ACK));

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      durum_r       <= BOSTA;
      sahip_r       <= 1'b0;
      rr_r          <= 1'b0;
      sayac_r       <= '0;
      alt_istek_r   <= '0;
      alt_gecerli_r <= 1'b0;
      kilit_r       <= '0;
    end else begin
      durum_r       <= durum_d;
      sahip_r       <= sahip_d;
      rr_r          <= rr_d;
      sayac_r       <= sayac_d;
      alt_istek_r   <= alt_istek_d;
      alt_gecerli_r <= alt_gecerli_d;
      kilit_r       <= kilit_d;
    end
  end

  always_comb begin
    durum_d            = durum_r;
    sahip_d            = sahip_r;
    rr_d               = rr_r;
    sayac_d            = sayac_r;
    alt_istek_d        = alt_istek_r;
    alt_gecerli_d      = alt_gecerli_r;
    kilit_d            = kilit_r;
    ist_hazir_o        = '0;
    yanit_gecerli_o    = '0;
    yanit_veri_o       = '0;
    yanit_tilefields_o = '0;
    alt_yanit_hazir_o  = 1'b0;

    unique case (durum_r)
      BOSTA: begin
        ist_hazir_o = grant;
        if (|grant) begin
          sahip_d       = grant[1];
          alt_istek_d   = istek[grant[1]];
          alt_gecerli_d = 1'b1;
          durum_d       = ISTEK;
        end
      end
      ISTEK: begin
        if (alt_gecerli_r && alt_hazir_i) begin
          alt_gecerli_d = 1'b0;
          durum_d       = YANIT_BEKLE;
        end
      end
      YANIT_BEKLE: begin
        yanit_gecerli_o[sahip_r] = alt_yanit_gecerli_i;
        yanit_veri_o             = alt_yanit_veri_i;
        yanit_tilefields_o       = alt_yanit_tilefields_i;
        alt_yanit_hazir_o        = yanit_hazir_i[sahip_r];
        if (yanit_tamam) begin
          if (ist_kilit_i[sahip_r]) begin
            durum_d = KILITLI;
            kilit_d = {sahip_r, ~sahip_r};
            sayac_d = '0;
          end else begin
            durum_d = BOSTA;
            rr_d    = ~sahip_r;
            kilit_d = '0;
          end
        end
      end
      KILITLI: begin
        // Owner request beats both a kilit drop and a timeout in the same cycle
        if (ist_gecerli_i[sahip_r]) begin
          ist_hazir_o[sahip_r] = 1'b1;
          alt_istek_d          = istek[sahip_r];
          alt_gecerli_d        = 1'b1;
          sayac_d              = '0;
          durum_d              = ISTEK;
        end else if (!ist_kilit_i[sahip_r] ||
                     ((KILIT_ZAMAN_ASIMI != 0) && (sayac_r == KILIT_ZAMAN_ASIMI - 32'd1))) begin
          durum_d = BOSTA;
          rr_d    = ~sahip_r;
          kilit_d = '0;
        end else begin
          sayac_d = 32'(sayac_r + 32'd1);
        end
      end
      default: durum_d = BOSTA;
    endcase
  end

  assign alt_adres_o      = alt_istek_r.adres;
  assign alt_veri_o       = alt_istek_r.veri;
  assign alt_tilefields_o = alt_istek_r.tilefields;
  assign alt_gecerli_o    = alt_gecerli_r;
  assign kilit_sahibi_o   = kilit_r;

endmodule

// File: tb/tb_spi_erisim_hakemi.sv
// Directed bench for spi_erisim_hakemi: round-robin, locking, backpressure,
// lock timeout, ACK completion and asynchronous reset.
module tb_spi_erisim_hakemi;
  import spi_erisim_hakemi_pkg::*;

  localparam logic [31:0] A0        = 32'h0000_1000;
  localparam logic [31:0] A1        = 32'h0000_2000;
  localparam logic [31:0] ADR_CMD   = 32'h1000_0004;
  localparam logic [31:0] ADR_WDATA = 32'h1000_0008;
  localparam logic [31:0] ADR_RDATA = 32'h1000_000C;

  logic                   clk_i;
  logic                   rstn_i;
  logic [2*ADRES_BIT-1:0] ist_adres_i;
  logic [2*VERI_BIT-1:0]  ist_veri_i;
  logic [2*TL_A_BITS-1:0] ist_tilefields_i;
  logic [1:0]             ist_gecerli_i;
  logic [1:0]             ist_hazir_o;
  logic [1:0]             ist_kilit_i;
  logic [VERI_BIT-1:0]    yanit_veri_o;
  logic [TL_D_BITS-1:0]   yanit_tilefields_o;
  logic [1:0]             yanit_gecerli_o;
  logic [1:0]             yanit_hazir_i;
  logic [ADRES_BIT-1:0]   alt_adres_o;
  logic [VERI_BIT-1:0]    alt_veri_o;
  logic [TL_A_BITS-1:0]   alt_tilefields_o;
  logic                   alt_gecerli_o;
  logic                   alt_hazir_i;
  logic [VERI_BIT-1:0]    alt_yanit_veri_i;
  logic [TL_D_BITS-1:0]   alt_yanit_tilefields_i;
  logic                   alt_yanit_gecerli_i;
  logic                   alt_yanit_hazir_o;
  logic [1:0]             kilit_sahibi_o;

  int n_chk  = 0;
  int n_fail = 0;

  spi_erisim_hakemi #(.KILIT_ZAMAN_ASIMI(8)) dut (
    .clk_i                  (clk_i),
    .rstn_i                 (rstn_i),
    .ist_adres_i            (ist_adres_i),
    .ist_veri_i             (ist_veri_i),
    .ist_tilefields_i       (ist_tilefields_i),
    .ist_gecerli_i          (ist_gecerli_i),
    .ist_hazir_o            (ist_hazir_o),
    .ist_kilit_i            (ist_kilit_i),
    .yanit_veri_o           (yanit_veri_o),
    .yanit_tilefields_o     (yanit_tilefields_o),
    .yanit_gecerli_o        (yanit_gecerli_o),
    .yanit_hazir_i          (yanit_hazir_i),
    .alt_adres_o            (alt_adres_o),
    .alt_veri_o             (alt_veri_o),
    .alt_tilefields_o       (alt_tilefields_o),
    .alt_gecerli_o          (alt_gecerli_o),
    .alt_hazir_i            (alt_hazir_i),
    .alt_yanit_veri_i       (alt_yanit_veri_i),
    .alt_yanit_tilefields_i (alt_yanit_tilefields_i),
    .alt_yanit_gecerli_i    (alt_yanit_gecerli_i),
    .alt_yanit_hazir_o      (alt_yanit_hazir_o),
    .kilit_sahibi_o         (kilit_sahibi_o)
  );

  initial begin
    clk_i = 1'b0;
    forever #5 clk_i = ~clk_i;
  end

  task automatic tick();
    @(posedge clk_i);
    #2;
  endtask

  // From ISTEK: controller accepts, then returns an AccessAckData that is taken
  task automatic istek_bitir();
    alt_hazir_i = 1'b1;
    tick();
    alt_hazir_i            = 1'b0;
    alt_yanit_gecerli_i    = 1'b1;
    alt_yanit_tilefields_i = {5'd0, TL_OP_ACK_DATA};
    yanit_hazir_i          = 2'b11;
    tick();
    alt_yanit_gecerli_i = 1'b0;
    yanit_hazir_i       = 2'b00;
  endtask

  task automatic test_reset();
    rstn_i = 1'b0;
    tick();
    tick();
    n_chk++; if (alt_gecerli_o !== 1'b0) begin n_fail++; $display("FAIL reset_alt_gecerli: got %b expected 0", alt_gecerli_o); end
    n_chk++; if (alt_adres_o !== 32'h0) begin n_fail++; $display("FAIL reset_alt_adres: got %h expected 0", alt_adres_o); end
    n_chk++; if (ist_hazir_o !== 2'b00) begin n_fail++; $display("FAIL reset_ist_hazir: got %b expected 00", ist_hazir_o); end
    n_chk++; if (yanit_gecerli_o !== 2'b00) begin n_fail++; $display("FAIL reset_yanit_gecerli: got %b expected 00", yanit_gecerli_o); end
    n_chk++; if (kilit_sahibi_o !== 2'b00) begin n_fail++; $display("FAIL reset_kilit_sahibi: got %b expected 00", kilit_sahibi_o); end
    rstn_i = 1'b1;
    tick();
  endtask

  task automatic test_round_robin();
    ist_adres_i   = {A1, A0};
    ist_veri_i    = {32'h1111_1111, 32'h0000_0000};
    ist_gecerli_i = 2'b11;
    #1;
    n_chk++; if (ist_hazir_o !== 2'b01) begin n_fail++; $display("FAIL rr_first_grant: got %b expected 01", ist_hazir_o); end
    tick();
    n_chk++; if (alt_gecerli_o !== 1'b1) begin n_fail++; $display("FAIL rr_alt_gecerli: got %b expected 1", alt_gecerli_o); end
    n_chk++; if (alt_adres_o !== A0) begin n_fail++; $display("FAIL rr_alt_adres0: got %h expected %h", alt_adres_o, A0); end
    ist_gecerli_i = 2'b10;
    #1;
    n_chk++; if (ist_hazir_o !== 2'b00) begin n_fail++; $display("FAIL rr_istek_no_hazir: got %b expected 00", ist_hazir_o); end
    alt_hazir_i = 1'b1;
    tick();
    n_chk++; if (alt_gecerli_o !== 1'b0) begin n_fail++; $display("FAIL rr_alt_gecerli_drop: got %b expected 0", alt_gecerli_o); end
    alt_hazir_i            = 1'b0;
    alt_yanit_gecerli_i    = 1'b1;
    alt_yanit_tilefields_i = {5'd0, TL_OP_ACK};
    yanit_hazir_i          = 2'b01;
    #1;
    n_chk++; if (yanit_gecerli_o !== 2'b01) begin n_fail++; $display("FAIL rr_yanit_route0: got %b expected 01", yanit_gecerli_o); end
    tick();
    alt_yanit_gecerli_i = 1'b0;
    yanit_hazir_i       = 2'b00;
    ist_gecerli_i       = 2'b11;
    #1;
    n_chk++; if (ist_hazir_o !== 2'b10) begin n_fail++; $display("FAIL rr_second_grant: got %b expected 10", ist_hazir_o); end
    tick();
    ist_gecerli_i = 2'b00;
    n_chk++; if (alt_adres_o !== A1) begin n_fail++; $display("FAIL rr_alt_adres1: got %h expected %h", alt_adres_o, A1); end
    istek_bitir();
  endtask

  task automatic test_lock_sequence();
    logic [31:0] adr [3];
    adr[0] = ADR_CMD;
    adr[1] = ADR_WDATA;
    adr[2] = ADR_RDATA;
    ist_adres_i   = {adr[0], A0};
    ist_kilit_i   = 2'b10;
    ist_gecerli_i = 2'b10;
    #1;
    n_chk++; if (ist_hazir_o !== 2'b10) begin n_fail++; $display("FAIL lock_first_grant: got %b expected 10", ist_hazir_o); end
    tick();
    ist_gecerli_i = 2'b01;
    for (int i = 0; i < 3; i++) begin
      #1;
      n_chk++; if (alt_adres_o !== adr[i]) begin n_fail++; $display("FAIL lock_alt_adres%0d: got %h expected %h", i, alt_adres_o, adr[i]); end
      n_chk++; if (ist_hazir_o !== 2'b00) begin n_fail++; $display("FAIL lock_istek_hazir%0d: got %b expected 00", i, ist_hazir_o); end
      istek_bitir();
      #1;
      n_chk++; if (kilit_sahibi_o !== 2'b10) begin n_fail++; $display("FAIL lock_sahibi%0d: got %b expected 10", i, kilit_sahibi_o); end
      n_chk++; if (ist_hazir_o !== 2'b00) begin n_fail++; $display("FAIL lock_req0_ignored%0d: got %b expected 00", i, ist_hazir_o); end
      if (i < 2) begin
        ist_adres_i[63:32] = adr[i+1];
        ist_gecerli_i      = 2'b11;
        #1;
        n_chk++; if (ist_hazir_o !== 2'b10) begin n_fail++; $display("FAIL lock_owner_grant%0d: got %b expected 10", i, ist_hazir_o); end
        tick();
        ist_gecerli_i = 2'b01;
      end
    end
    ist_kilit_i = 2'b00;
    #1;
    n_chk++; if (ist_hazir_o !== 2'b00) begin n_fail++; $display("FAIL lock_release_cycle: got %b expected 00", ist_hazir_o); end
    tick();
    n_chk++; if (ist_hazir_o !== 2'b01) begin n_fail++; $display("FAIL lock_req0_after: got %b expected 01", ist_hazir_o); end
    n_chk++; if (kilit_sahibi_o !== 2'b00) begin n_fail++; $display("FAIL lock_sahibi_clear: got %b expected 00", kilit_sahibi_o); end
    tick();
    ist_gecerli_i = 2'b00;
    n_chk++; if (alt_adres_o !== A0) begin n_fail++; $display("FAIL lock_req0_adres: got %h expected %h", alt_adres_o, A0); end
    istek_bitir();
  endtask

  task automatic test_backpressure();
    ist_adres_i   = {A1, ADR_RDATA};
    ist_gecerli_i = 2'b01;
    tick();
    ist_gecerli_i = 2'b00;
    alt_hazir_i   = 1'b1;
    tick();
    alt_hazir_i            = 1'b0;
    alt_yanit_gecerli_i    = 1'b1;
    alt_yanit_veri_i       = 32'hA5A5_0F0F;
    alt_yanit_tilefields_i = {5'd0, TL_OP_ACK_DATA};
    yanit_hazir_i          = 2'b00;
    for (int c = 0; c < 5; c++) begin
      #1;
      n_chk++; if (yanit_gecerli_o !== 2'b01) begin n_fail++; $display("FAIL bp_yanit_gecerli%0d: got %b expected 01", c, yanit_gecerli_o); end
      n_chk++; if (yanit_veri_o !== 32'hA5A5_0F0F) begin n_fail++; $display("FAIL bp_yanit_veri%0d: got %h expected a5a50f0f", c, yanit_veri_o); end
      n_chk++; if (alt_yanit_hazir_o !== 1'b0) begin n_fail++; $display("FAIL bp_alt_hazir%0d: got %b expected 0", c, alt_yanit_hazir_o); end
      tick();
    end
    ist_gecerli_i = 2'b10;
    #1;
    n_chk++; if (ist_hazir_o !== 2'b00) begin n_fail++; $display("FAIL bp_still_waiting: got %b expected 00", ist_hazir_o); end
    ist_gecerli_i = 2'b00;
    yanit_hazir_i = 2'b01;
    #1;
    n_chk++; if (alt_yanit_hazir_o !== 1'b1) begin n_fail++; $display("FAIL bp_alt_hazir_pass: got %b expected 1", alt_yanit_hazir_o); end
    tick();
    yanit_hazir_i = 2'b11;
    #1;
    n_chk++; if (yanit_gecerli_o !== 2'b00) begin n_fail++; $display("FAIL spurious_yanit_gecerli: got %b expected 00", yanit_gecerli_o); end
    n_chk++; if (alt_yanit_hazir_o !== 1'b0) begin n_fail++; $display("FAIL spurious_alt_hazir: got %b expected 0", alt_yanit_hazir_o); end
    alt_yanit_gecerli_i = 1'b0;
    alt_yanit_veri_i    = '0;
    yanit_hazir_i       = 2'b00;
  endtask

  task automatic test_lock_timeout();
    ist_adres_i   = {A1, A0};
    ist_kilit_i   = 2'b10;
    ist_gecerli_i = 2'b10;
    tick();
    ist_gecerli_i = 2'b00;
    istek_bitir();
    ist_gecerli_i = 2'b01;
    for (int c = 1; c <= 8; c++) begin
      #1;
      n_chk++; if (ist_hazir_o !== 2'b00) begin n_fail++; $display("FAIL to_idle_hazir%0d: got %b expected 00", c, ist_hazir_o); end
      n_chk++; if (kilit_sahibi_o !== 2'b10) begin n_fail++; $display("FAIL to_idle_sahibi%0d: got %b expected 10", c, kilit_sahibi_o); end
      tick();
    end
    n_chk++; if (ist_hazir_o !== 2'b01) begin n_fail++; $display("FAIL to_req0_grant: got %b expected 01", ist_hazir_o); end
    n_chk++; if (kilit_sahibi_o !== 2'b00) begin n_fail++; $display("FAIL to_sahibi_clear: got %b expected 00", kilit_sahibi_o); end
    ist_kilit_i = 2'b00;
    tick();
    ist_gecerli_i = 2'b00;
    n_chk++; if (alt_gecerli_o !== 1'b1) begin n_fail++; $display("FAIL to_req0_alt_gecerli: got %b expected 1", alt_gecerli_o); end
    n_chk++; if (alt_adres_o !== A0) begin n_fail++; $display("FAIL to_req0_adres: got %h expected %h", alt_adres_o, A0); end
    istek_bitir();
  endtask

  task automatic test_ack_pulse();
    ist_gecerli_i = 2'b01;
    tick();
    ist_gecerli_i = 2'b00;
    alt_hazir_i   = 1'b1;
    tick();
    alt_hazir_i            = 1'b0;
    alt_yanit_gecerli_i    = 1'b1;
    alt_yanit_tilefields_i = {5'd0, TL_OP_ACK};
    yanit_hazir_i          = 2'b00;
    #1;
    n_chk++; if (yanit_gecerli_o !== 2'b01) begin n_fail++; $display("FAIL ack_yanit_gecerli: got %b expected 01", yanit_gecerli_o); end
    n_chk++; if (alt_yanit_hazir_o !== 1'b0) begin n_fail++; $display("FAIL ack_alt_hazir: got %b expected 0", alt_yanit_hazir_o); end
    tick();
    alt_yanit_gecerli_i = 1'b0;
    ist_gecerli_i       = 2'b10;
    #1;
    n_chk++; if (ist_hazir_o !== 2'b10) begin n_fail++; $display("FAIL ack_left_yanit: got %b expected 10", ist_hazir_o); end
    tick();
  endtask

  task automatic test_async_reset();
    ist_gecerli_i = 2'b00;
    #1;
    n_chk++; if (alt_gecerli_o !== 1'b1) begin n_fail++; $display("FAIL ar_in_istek: got %b expected 1", alt_gecerli_o); end
    rstn_i = 1'b0;
    #1;
    n_chk++; if (alt_gecerli_o !== 1'b0) begin n_fail++; $display("FAIL ar_alt_gecerli: got %b expected 0", alt_gecerli_o); end
    n_chk++; if (alt_adres_o !== 32'h0) begin n_fail++; $display("FAIL ar_alt_adres: got %h expected 0", alt_adres_o); end
    n_chk++; if (ist_hazir_o !== 2'b00) begin n_fail++; $display("FAIL ar_ist_hazir: got %b expected 00", ist_hazir_o); end
    n_chk++; if (yanit_gecerli_o !== 2'b00) begin n_fail++; $display("FAIL ar_yanit_gecerli: got %b expected 00", yanit_gecerli_o); end
    n_chk++; if (kilit_sahibi_o !== 2'b00) begin n_fail++; $display("FAIL ar_kilit_sahibi: got %b expected 00", kilit_sahibi_o); end
    tick();
    rstn_i        = 1'b1;
    ist_gecerli_i = 2'b11;
    #1;
    n_chk++; if (ist_hazir_o !== 2'b01) begin n_fail++; $display("FAIL ar_rr_reset: got %b expected 01", ist_hazir_o); end
    tick();
    ist_gecerli_i = 2'b00;
    n_chk++; if (alt_adres_o !== A0) begin n_fail++; $display("FAIL ar_regrant_adres: got %h expected %h", alt_adres_o, A0); end
  endtask

  initial begin
    rstn_i                 = 1'b0;
    ist_adres_i            = '0;
    ist_veri_i             = '0;
    ist_tilefields_i       = '0;
    ist_gecerli_i          = '0;
    ist_kilit_i            = '0;
    yanit_hazir_i          = '0;
    alt_hazir_i            = 1'b0;
    alt_yanit_veri_i       = '0;
    alt_yanit_tilefields_i = '0;
    alt_yanit_gecerli_i    = 1'b0;
    test_reset();
    test_round_robin();
    test_lock_sequence();
    test_backpressure();
    test_lock_timeout();
    test_ack_pulse();
    test_async_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/spi_erisim_hakemi.md
Name: spi_erisim_hakemi

Overview:
Two-port arbiter that shares the single TileLink-style request/response port of spi_denetleyici between requester 0 (core data port) and requester 1 (boot/flash loader).
- Only one request is in flight at a time.
- Arbitration is round-robin.
- A requester may lock the controller across a multi-access SPI sequence (CTRL, CMD, WDATA, RDATA), so another requester cannot interleave commands into its FIFOs.
- Sits between the interconnect/loader and spi_denetleyici.

Parameters:
KILIT_ZAMAN_ASIMI, 1024, idle cycles in KILITLI with no owner request before the lock is force-released (0 disables the timeout).

Ports:
clk_i  in  1  clock
rstn_i  in  1  asynchronous active-low reset
ist_adres_i  in  2x`ADRES_BIT  request address, packed, requester k at [k*`ADRES_BIT +: `ADRES_BIT]
ist_veri_i  in  2x`VERI_BIT  request write data
ist_tilefields_i  in  2x`TL_A_BITS  request A-channel fields
ist_gecerli_i  in  2  request valid, per requester
ist_hazir_o  out  2  request accepted, per requester
ist_kilit_i  in  2  hold grant after the current response, per requester
yanit_veri_o  out  `VERI_BIT  response data, shared bus
yanit_tilefields_o  out  `TL_D_BITS  response D-channel fields, shared bus
yanit_gecerli_o  out  2  response valid, per requester
yanit_hazir_i  in  2  response ready, per requester
alt_adres_o  out  `ADRES_BIT  to controller cek_adres_i
alt_veri_o  out  `VERI_BIT  to controller cek_veri_i
alt_tilefields_o  out  `TL_A_BITS  to controller cek_tilefields_i
alt_gecerli_o  out  1  to controller cek_gecerli_i
alt_hazir_i  in  1  from controller cek_hazir_o
alt_yanit_veri_i  in  `VERI_BIT  from controller spi_veri_o
alt_yanit_tilefields_i  in  `TL_D_BITS  from controller spi_tilefields_o
alt_yanit_gecerli_i  in  1  from controller spi_gecerli_o
alt_yanit_hazir_o  out  1  to controller spi_hazir_i
kilit_sahibi_o  out  2  one-hot lock owner (debug/status)

Behaviour:
- Reset (asynchronous, rstn_i low):
  - state BOSTA; sahip_r=0; rr_r=0 (requester 0 has priority); timeout counter 0.
  - All alt_* request registers 0; alt_gecerli_o=0; yanit_gecerli_o=0; ist_hazir_o=0; kilit_sahibi_o=0.
- States: BOSTA, ISTEK, YANIT_BEKLE, KILITLI.
- BOSTA:
  - Grant g = rr_r if ist_gecerli_i[rr_r] is high, else the other requester if its valid is high.
  - ist_hazir_o[g]=1 combinationally in the same cycle.
  - On that handshake: register g's adres/veri/tilefields into alt_*, set sahip_r=g, alt_gecerli_o=1 next cycle, go ISTEK.
  - Accept latency is one cycle; the request appears downstream on the following cycle.
- ISTEK:
  - Hold alt_* stable and alt_gecerli_o high until alt_gecerli_o && alt_hazir_i.
  - Then alt_gecerli_o=0 on the next cycle, go YANIT_BEKLE.
  - ist_hazir_o=0 throughout.
- YANIT_BEKLE (routing is combinational on the registered sahip_r):
  - yanit_gecerli_o[sahip_r] = alt_yanit_gecerli_i; the other bit is 0.
  - yanit_veri_o and yanit_tilefields_o pass through.
  - alt_yanit_hazir_o = yanit_hazir_i[sahip_r].
  - Response completes on alt_yanit_gecerli_i && (alt_yanit_hazir_o || D_OP==`TL_OP_ACK). The controller drops ACK after one cycle regardless of ready, so ACK pulses are single-cycle and must be consumed; this is a requester obligation.
  - On completion:
    - If ist_kilit_i[sahip_r] is high: go KILITLI, kilit_sahibi_o=onehot(sahip_r), clear the timeout counter.
    - Else: go BOSTA, rr_r = ~sahip_r.
- KILITLI:
  - Only the owner is granted: ist_hazir_o[sahip_r] = ist_gecerli_i[sahip_r]; the accept path is the same as BOSTA, then go ISTEK.
  - The other requester's valid is ignored, and it stalls.
  - Release to BOSTA (rr_r = ~sahip_r, kilit_sahibi_o=0) when either:
    - the owner drops ist_kilit_i with no valid request in the same cycle; or
    - the counter reaches KILIT_ZAMAN_ASIMI-1 with no owner request.
  - The counter increments each idle cycle and clears on each owner accept.
  - kilit_sahibi_o stays high through the ISTEK/YANIT_BEKLE phases of locked requests.
- Simultaneous events:
  - Both valid in BOSTA: rr_r wins.
  - Owner asserts valid in the same cycle the timeout would expire: the request wins and the counter clears.
  - Owner drops kilit and asserts valid in the same cycle: the request is accepted and the lock is evaluated again at the response.
- A spurious alt_yanit_gecerli_i outside YANIT_BEKLE is not routed; alt_yanit_hazir_o=0.
- Reset mid-transaction abandons the in-flight request. The controller shares rstn_i, so no recovery is required.
- No combinational path from ist_gecerli_i to alt_gecerli_o.

Decomposition:
- State encoding and the KILIT_ZAMAN_ASIMI default go in a shared spi_hakem_sabitleri.vh.
- Width and TL field macros come from sabitler.vh.
- One natural sub-module: rr_hakem2, the 2-input round-robin grant (valid, rr pointer to one-hot grant), purely combinational.
- Everything else stays flat.

Test Plan:
1. Both requesters valid at cycle 0 after reset -> requester 0 granted (ist_hazir_o=2'b01), alt_gecerli_o high at cycle 1. After its ACK, requester 1 is granted the next BOSTA cycle (ist_hazir_o=2'b10).
2. Requester 1 locks, then issues CMD write, WDATA write, and RDATA read while requester 0 is held valid throughout -> all three reach the controller back-to-back from requester 1. Requester 0 is granted only after requester 1 drops ist_kilit_i. kilit_sahibi_o=2'b10 during the sequence.
3. RDATA read with yanit_hazir_i[0] held low for 5 cycles -> yanit_gecerli_o[0] stays high and yanit_veri_o stable (e.g. 32'hA5A5_0F0F). State remains YANIT_BEKLE until ready.
4. KILIT_ZAMAN_ASIMI=8, owner locked and idle -> release on idle cycle 8. The waiting requester 0 is accepted the following cycle.
5. CTRL write ACK pulse of one cycle with requester ready low -> the response is counted complete and the state leaves YANIT_BEKLE the next cycle.
6. Assert rstn_i low asynchronously while in ISTEK -> all outputs are 0 immediately, state is BOSTA, and rr_r=0.
